// File: rtl/lpm_walker_pkg.sv
// lpm_walker_pkg: shared constants for the LPM trie walker.
//   State encodings, response-word layout (LEAF bit, child pointer width),
//   the 16/8/8 stride split of the key and the deepest trie level.
package lpm_walker_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] lvl_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam int LEAF_BIT  = 31;
    localparam int PTR_WIDTH = 24;
    localparam int STRIDE0   = 16;
    localparam int STRIDE1   = 8;
    localparam int STRIDE2   = 8;
    localparam int MAX_LEVEL = 2;

endpackage

// File: rtl/lpm_walker_addr.sv
// lpm_walker_addr: combinational next-address former.
//   start  in  1   forming the root (level-0) address from a fresh key
//   level  in  2   level of the response just received (0 or 1)
//   key    in  32  lookup key
//   ptr    in  24  child pointer from the response word
//   addr   out 32  address of the next read
module lpm_walker_addr
    import lpm_walker_pkg::*;
#(
    parameter logic [31:0] ROOT_BASE = 32'h0
) (
    input  logic                 start,
    input  logic [1:0]           level,
    input  logic [31:0]          key,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [31:0]          addr
);

    // Child node address is the pointer concatenated with the next key byte.
    always_comb begin
        addr = ROOT_BASE + {16'h0, key[31:32-STRIDE0]};
        if (!start) begin
            if (level == 2'd0)
                addr = {ptr, key[STRIDE1+STRIDE2-1:STRIDE2]};
            else
                addr = {ptr, key[STRIDE2-1:0]};
        end
    end

endmodule

// File: rtl/lpm_walker.sv
// lpm_walker: single-lookup LPM trie walker (16/8/8 strides).
//   Accepts a key on enter, issues one dependent read per level on the mem
//   client interface, returns leaf value and level on result.
//   Ports: CLK, nRST (async low); enter__ENA/enter_key/enter__RDY;
//   result__RDY/result_v/result_level/result__ENA; mem_req__ENA/mem_req_v/
//   mem_req__RDY; mem_resAccept__ENA/mem_resAccept__RDY; mem_resValue/
//   mem_resValue__RDY.
//   Optional: LPM_WALKER_STATS_EN adds stat_lookups / stat_reads counters.
module lpm_walker
    import lpm_walker_pkg::*;
#(
    parameter logic [31:0] ROOT_BASE = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        enter__ENA,
    input  logic [31:0] enter_key,
    output logic        enter__RDY,
    output logic        result__RDY,
    output logic [30:0] result_v,
    output logic [1:0]  result_level,
    input  logic        result__ENA,
    output logic        mem_req__ENA,
    output logic [31:0] mem_req_v,
    input  logic        mem_req__RDY,
    output logic        mem_resAccept__ENA,
    input  logic        mem_resAccept__RDY,
    input  logic [31:0] mem_resValue,
    input  logic        mem_resValue__RDY
`ifdef LPM_WALKER_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_reads
`endif
);

    state_t      state_q;
    lvl_t        level_q;
    logic [31:0] key_q;
    logic [31:0] addr_q;
    logic [30:0] res_v_q;
    lvl_t        res_lvl_q;

    logic        in_idle;
    logic        is_leaf;
    logic [31:0] form_key;
    logic [31:0] next_addr;

    assign in_idle            = (state_q == ST_IDLE);
    assign enter__RDY         = in_idle;
    assign result__RDY        = (state_q == ST_DONE);
    assign mem_req__ENA       = (state_q == ST_REQ) & mem_req__RDY;
    assign mem_resAccept__ENA = (state_q == ST_WAIT) & mem_resValue__RDY & mem_resAccept__RDY;
    assign mem_req_v          = addr_q;
    assign result_v           = res_v_q;
    assign result_level       = res_lvl_q;

    // The deepest level always terminates the walk, whatever its LEAF bit says.
    assign is_leaf  = mem_resValue[LEAF_BIT] | (level_q == lvl_t'(MAX_LEVEL));
    assign form_key = in_idle ? enter_key : key_q;

    lpm_walker_addr #(.ROOT_BASE(ROOT_BASE)) u_addr (
        .start (in_idle),
        .level (level_q),
        .key   (form_key),
        .ptr   (mem_resValue[PTR_WIDTH-1:0]),
        .addr  (next_addr)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            key_q     <= '0;
            addr_q    <= '0;
            res_v_q   <= '0;
            res_lvl_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (enter__ENA) begin
                    key_q   <= enter_key;
                    level_q <= '0;
                    addr_q  <= next_addr;
                    state_q <= ST_REQ;
                end
                ST_REQ: if (mem_req__RDY) state_q <= ST_WAIT;
                ST_WAIT: if (mem_resAccept__ENA) begin
                    if (is_leaf) begin
                        res_v_q   <= mem_resValue[30:0];
                        res_lvl_q <= level_q;
                        state_q   <= ST_DONE;
                    end else begin
                        addr_q  <= next_addr;
                        level_q <= level_q + 2'd1;
                        state_q <= ST_REQ;
                    end
                end
                ST_DONE: if (result__ENA) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LPM_WALKER_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups <= '0;
            stat_reads   <= '0;
        end else begin
            if (result__RDY & result__ENA) stat_lookups <= stat_lookups + 32'd1;
            if (mem_req__ENA)              stat_reads   <= stat_reads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lpm_walker.sv
// tb_lpm_walker: randomized self-checking bench for lpm_walker.
//   A behavioural trie model (override table + hashed default contents)
//   predicts read addresses and results; a memory server with random
//   latency and backpressure answers the walker's reads.
module tb_lpm_walker;

    localparam logic [31:0] ROOT = 32'h0;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        enter__ENA = 1'b0;
    logic [31:0] enter_key = '0;
    logic        enter__RDY;
    logic        result__RDY;
    logic [30:0] result_v;
    logic [1:0]  result_level;
    logic        result__ENA = 1'b0;
    logic        mem_req__ENA;
    logic [31:0] mem_req_v;
    logic        mem_req__RDY;
    logic        mem_resAccept__ENA;
    logic        mem_resAccept__RDY;
    logic [31:0] mem_resValue;
    logic        mem_resValue__RDY;
`ifdef LPM_WALKER_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_reads;
`endif

    lpm_walker #(.ROOT_BASE(ROOT)) dut (
        .CLK(CLK), .nRST(nRST),
        .enter__ENA(enter__ENA), .enter_key(enter_key), .enter__RDY(enter__RDY),
        .result__RDY(result__RDY), .result_v(result_v), .result_level(result_level),
        .result__ENA(result__ENA),
        .mem_req__ENA(mem_req__ENA), .mem_req_v(mem_req_v), .mem_req__RDY(mem_req__RDY),
        .mem_resAccept__ENA(mem_resAccept__ENA), .mem_resAccept__RDY(mem_resAccept__RDY),
        .mem_resValue(mem_resValue), .mem_resValue__RDY(mem_resValue__RDY)
`ifdef LPM_WALKER_STATS_EN
        , .stat_lookups(stat_lookups), .stat_reads(stat_reads)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory contents and reference model ----------------
    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        return h;
    endfunction

    logic [31:0] exp_addrs[$];
    logic [30:0] exp_v;
    logic [1:0]  exp_lvl;
    logic [31:0] cur_key;
    int unsigned exp_lookups = 0;
    int unsigned exp_reads = 0;

    task automatic ref_walk(input logic [31:0] key);
        logic [31:0] a, w;
        logic [7:0]  byte_sel;
        exp_addrs.delete();
        a = ROOT + (key >> 16);
        for (int l = 0; l < 3; l++) begin
            exp_addrs.push_back(a);
            w = mem_rd(a);
            if (w[31] || l == 2) begin
                exp_v = w[30:0];
                exp_lvl = 2'(l);
                break;
            end
            byte_sel = (l == 0) ? key[15:8] : key[7:0];
            a = (w % 32'h0100_0000) * 256 + 32'(byte_sel);
        end
    endtask

    // ---------------- memory server ----------------
    int unsigned lat_max = 1;
    int unsigned stall_pct = 0;
    bit force_req_stall = 0;
    bit force_acc_stall = 0;
    int unsigned proto_err = 0;
    logic [31:0] got_addrs[$];

    initial begin
        bit          pend;
        int unsigned cnt;
        logic [31:0] rdata, s_addr;
        logic        s_req, s_acc;
        pend = 0; cnt = 0; rdata = '0;
        mem_req__RDY = 0; mem_resAccept__RDY = 0;
        mem_resValue = '0; mem_resValue__RDY = 0;
        forever begin
            @(negedge CLK);
            s_req = mem_req__ENA; s_acc = mem_resAccept__ENA; s_addr = mem_req_v;
            if (s_req && s_acc) proto_err++;
            @(posedge CLK); #1;
            if (!nRST) begin
                pend = 0;
                mem_resValue__RDY = 0;
            end else begin
                if (s_acc) begin pend = 0; mem_resValue__RDY = 0; end
                if (s_req) begin
                    if (pend) proto_err++;
                    got_addrs.push_back(s_addr);
                    pend = 1;
                    cnt = $urandom_range(lat_max, 0);
                    rdata = mem_rd(s_addr);
                end
                if (pend && !mem_resValue__RDY) begin
                    if (cnt == 0) begin
                        mem_resValue__RDY = 1;
                        mem_resValue = rdata;
                    end else cnt--;
                end
            end
            mem_req__RDY       = !force_req_stall && ($urandom_range(99, 0) >= stall_pct);
            mem_resAccept__RDY = !force_acc_stall && ($urandom_range(99, 0) >= stall_pct);
        end
    end

    // ---------------- lookup driver ----------------
    task automatic start_lookup(input logic [31:0] key);
        int t = 0;
        ref_walk(key);
        got_addrs.delete();
        cur_key = key;
        while (!enter__RDY && t < 200) begin @(negedge CLK); t++; end
        chk("enter_rdy_wait", 32'(enter__RDY), 32'd1);
        enter_key = key; enter__ENA = 1;
        @(negedge CLK);
        enter__ENA = 0;
    endtask

    task automatic finish_lookup(input string tag, input int stall);
        int t = 0;
        bit unstable = 0;
        logic [30:0] v0;
        int unsigned nreads;
        while (!result__RDY && t < 1000) begin @(negedge CLK); t++; end
        chk({tag, "_done"}, 32'(result__RDY), 32'd1);
        chk({tag, "_v"}, 32'(result_v), 32'(exp_v));
        chk({tag, "_level"}, 32'(result_level), 32'(exp_lvl));
        chk({tag, "_nreads"}, got_addrs.size(), exp_addrs.size());
        for (int i = 0; i < exp_addrs.size(); i++)
            chk({tag, "_addr"}, (i < got_addrs.size()) ? got_addrs[i] : 32'hDEAD_BEEF, exp_addrs[i]);
        v0 = result_v;
        nreads = got_addrs.size();
        for (int i = 0; i < stall; i++) begin
            enter__ENA = 1; enter_key = ~cur_key;
            @(negedge CLK);
            if (result_v !== v0 || enter__RDY !== 1'b0 || result__RDY !== 1'b1) unstable = 1;
        end
        enter__ENA = 0;
        if (stall > 0) begin
            chk({tag, "_stall_stable"}, 32'(unstable), 32'd0);
            chk({tag, "_stall_noread"}, got_addrs.size(), nreads);
        end
        result__ENA = 1;
        @(negedge CLK);
        result__ENA = 0;
        chk({tag, "_idle_next"}, {30'd0, enter__RDY, result__RDY}, 32'd2);
        exp_lookups++;
        exp_reads += exp_addrs.size();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"}, {28'd0, enter__RDY, result__RDY, mem_req__ENA, mem_resAccept__ENA}, 32'h8);
        chk({tag, "_v"}, 32'(result_v), 32'd0);
        chk({tag, "_level"}, 32'(result_level), 32'd0);
        chk({tag, "_addr"}, mem_req_v, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        nRST = 1;
        @(negedge CLK);

        // Level-0 leaf
        mem_ovr[32'h0000_0A01] = 32'h8000_0055;
        start_lookup(32'h0A01_0203);
        finish_lookup("l0_leaf", 0);

        // Full walk, LEAF bit absent at level 2
        mem_ovr[32'h0000_0A01] = 32'h0000_0100;
        mem_ovr[32'h0001_0002] = 32'h0000_0200;
        mem_ovr[32'h0002_0003] = 32'h0000_0777;
        start_lookup(32'h0A01_0203);
        finish_lookup("full_walk", 0);

        // Backpressure: no request for 5 cycles, no accept for 3 cycles
        mem_ovr[32'h0000_0B02] = 32'h8123_4567;
        force_req_stall = 1; force_acc_stall = 1;
        @(negedge CLK); @(negedge CLK);
        start_lookup(32'h0B02_0000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_no_req", {31'd0, mem_req__ENA}, 32'd0);
            @(negedge CLK);
        end
        chk("bp_no_read_yet", got_addrs.size(), 0);
        force_req_stall = 0;
        t = 0;
        while (got_addrs.size() == 0 && t < 50) begin @(negedge CLK); t++; end
        for (int i = 0; i < 3; i++) begin
            chk("bp_no_accept", {30'd0, mem_resAccept__ENA, result__RDY}, 32'd0);
            @(negedge CLK);
        end
        force_acc_stall = 0;
        finish_lookup("backpressure", 0);

        // Result stall with ignored enter
        start_lookup(32'h0A01_0203);
        finish_lookup("res_stall", 10);

        // Reset in the middle of level 1
        lat_max = 3;
        start_lookup(32'h0A01_0203);
        t = 0;
        while (got_addrs.size() < 2 && t < 300) begin @(negedge CLK); t++; end
        chk("rst_reached_l1", got_addrs.size(), 2);
        nRST = 0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge CLK); @(negedge CLK);
        nRST = 1;
        exp_lookups = 0; exp_reads = 0;
        @(negedge CLK);
        start_lookup(32'h0A01_0203);
        finish_lookup("after_reset", 0);

        // Level-0 leaf again so the stats see both ends of the depth range
        mem_ovr[32'h0000_0C03] = 32'h8000_0001;
        start_lookup(32'h0C03_FFFF);
        finish_lookup("l0_again", 0);
`ifdef LPM_WALKER_STATS_EN
        chk("stat_lookups_2", stat_lookups, exp_lookups);
        chk("stat_reads_4", stat_reads, exp_reads);
`endif

        // Random keys over hashed trie contents with random latency/backpressure
        stall_pct = 30;
        for (int n = 0; n < 40; n++) begin
            start_lookup($urandom());
            finish_lookup("rand", $urandom_range(2, 0));
        end

        chk("protocol", proto_err, 0);
`ifdef LPM_WALKER_STATS_EN
        chk("stat_lookups", stat_lookups, exp_lookups);
        chk("stat_reads", stat_reads, exp_reads);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
